// File: rtl/dffnq_pipe_pkg.sv
// Shared definitions for the falling-edge register pipeline bank.
package dffnq_pipe_pkg;

  localparam logic RST_VAL = 1'b0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffnq_pipe_stage.sv
// One pipeline stage: WIDTH data flops plus a valid tag, all on the falling edge.
// Scan mux present when DFFNQ_PIPE_BANK_SCAN_EN is defined.
module dffnq_pipe_stage
  import dffnq_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clkn_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             v_i,
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
  input  logic             se_i,
  input  logic             si_i,
`endif
  output logic [WIDTH-1:0] d_o,
  output logic             v_o
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } stage_t;

  stage_t st_q, st_d;

  always_comb begin
    st_d = st_q;
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
    if (se_i) begin
      // Scan moves data bits only; the tag keeps its value.
      st_d.d = WIDTH'({st_q.d, si_i});
    end else
`endif
    if (clr_i) begin
      st_d.v = 1'b0;
    end else if (en_i) begin
      st_d.v = v_i;
      st_d.d = d_i;
    end
  end

  always_ff @(negedge clkn_i or posedge rst_i) begin
    if (rst_i) st_q <= {(WIDTH + 1){RST_VAL}};
    else       st_q <= st_d;
  end

  assign d_o = st_q.d;
  assign v_o = st_q.v;

endmodule

// File: rtl/dffnq_pipe_bank.sv
// Falling-edge WIDTH x DEPTH register pipeline with valid tags, stall, flush and occupancy count.
// Optional scan chain enabled by defining DFFNQ_PIPE_BANK_SCAN_EN.
module dffnq_pipe_bank
  import dffnq_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      CLKN,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      FLUSH,
  input  logic [WIDTH-1:0]          D,
  input  logic                      DV,
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
  input  logic                      SE,
  input  logic                      SI,
  output logic                      SO,
`endif
  output logic [WIDTH-1:0]          Q,
  output logic                      QV,
  output logic [cnt_w(DEPTH)-1:0]   CNT
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] sd   [DEPTH];
  logic [WIDTH-1:0] in_d [DEPTH];
  logic [DEPTH-1:0] sv;
  logic [DEPTH-1:0] in_v;
  logic             se_act;
  logic [CW-1:0]    cnt_q, cnt_d;

`ifdef DFFNQ_PIPE_BANK_SCAN_EN
  logic [DEPTH-1:0] in_si;
  assign se_act = SE;
  assign SO     = sd[DEPTH-1][WIDTH-1];
`else
  assign se_act = 1'b0;
`endif

  assign in_d[0] = D;
  assign in_v[0] = DV;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign in_d[i] = sd[i-1];
      assign in_v[i] = sv[i-1];
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
      assign in_si[i] = sd[i-1][WIDTH-1];
`endif
    end else begin : g_head
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
      assign in_si[0] = SI;
`endif
    end

    dffnq_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clkn_i (CLKN),
      .rst_i  (RST),
      .en_i   (EN),
      .clr_i  (FLUSH),
      .d_i    (in_d[i]),
      .v_i    (in_v[i]),
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
      .se_i   (SE),
      .si_i   (in_si[i]),
`endif
      .d_o    (sd[i]),
      .v_o    (sv[i])
    );
  end

  // Count tracks tags incrementally: one enters with DV, one leaves from the last stage.
  always_comb begin
    cnt_d = cnt_q;
    if (se_act) begin
      cnt_d = cnt_q;
    end else if (FLUSH) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = cnt_q + CW'(DV) - CW'(sv[DEPTH-1]);
    end
  end

  always_ff @(negedge CLKN or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Q   = sd[DEPTH-1];
  assign QV  = sv[DEPTH-1];
  assign CNT = cnt_q;

`ifndef SYNTHESIS
  a_cnt_popcount: assert property (@(posedge CLKN) disable iff (RST)
    cnt_q == CW'($countones(sv)));
`endif

endmodule

// File: tb/tb_dffnq_pipe_bank.sv
// Directed bench for dffnq_pipe_bank (WIDTH=8, DEPTH=4); scan test under DFFNQ_PIPE_BANK_SCAN_EN.
module tb_dffnq_pipe_bank;

  logic       CLKN = 1'b1;
  logic       RST, EN, FLUSH, DV;
  logic [7:0] D;
  logic [7:0] Q;
  logic       QV;
  logic [2:0] CNT;
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
  logic SE = 1'b0, SI = 1'b0, SO;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  dffnq_pipe_bank #(.WIDTH(8), .DEPTH(4)) dut (
    .CLKN  (CLKN),
    .RST   (RST),
    .EN    (EN),
    .FLUSH (FLUSH),
    .D     (D),
    .DV    (DV),
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
    .SE    (SE),
    .SI    (SI),
    .SO    (SO),
`endif
    .Q     (Q),
    .QV    (QV),
    .CNT   (CNT)
  );

  always #5 CLKN = ~CLKN;

  task automatic tick();
    @(negedge CLKN);
    #1;
  endtask

  task automatic do_reset();
    EN = 1'b0; FLUSH = 1'b0; D = 8'h00; DV = 1'b0;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; FLUSH = 1'b0; D = 8'hFF; DV = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (Q !== 8'h00) begin n_bad++; $display("FAIL reset_q[%0d]: got %h want 00", i, Q); end
      n_cmp++; if (QV !== 1'b0) begin n_bad++; $display("FAIL reset_qv[%0d]: got %b want 0", i, QV); end
      n_cmp++; if (CNT !== 3'd0) begin n_bad++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, CNT); end
    end
    RST = 1'b0;
    tick();
    n_cmp++; if (CNT !== 3'd1) begin n_bad++; $display("FAIL release_cnt: got %0d want 1", CNT); end
    n_cmp++; if (QV !== 1'b0) begin n_bad++; $display("FAIL release_qv: got %b want 0", QV); end
    tick(); tick(); tick();
    n_cmp++; if (Q !== 8'hFF || QV !== 1'b1) begin n_bad++; $display("FAIL release_fill: got %h/%b want ff/1", Q, QV); end
    n_cmp++; if (CNT !== 3'd4) begin n_bad++; $display("FAIL release_cnt4: got %0d want 4", CNT); end
  endtask

  task automatic test_latency();
    do_reset();
    EN = 1'b1; D = 8'hA5; DV = 1'b1;
    tick();
    D = 8'h00; DV = 1'b0;
    n_cmp++; if (CNT !== 3'd1 || QV !== 1'b0) begin n_bad++; $display("FAIL lat_e0: got cnt %0d qv %b want 1/0", CNT, QV); end
    for (int e = 1; e < 3; e++) begin
      tick();
      n_cmp++; if (CNT !== 3'd1 || QV !== 1'b0) begin n_bad++; $display("FAIL lat_e%0d: got cnt %0d qv %b want 1/0", e, CNT, QV); end
    end
    tick();
    n_cmp++; if (Q !== 8'hA5 || QV !== 1'b1) begin n_bad++; $display("FAIL lat_e3_q: got %h/%b want a5/1", Q, QV); end
    n_cmp++; if (CNT !== 3'd1) begin n_bad++; $display("FAIL lat_e3_cnt: got %0d want 1", CNT); end
    tick();
    n_cmp++; if (CNT !== 3'd0 || QV !== 1'b0) begin n_bad++; $display("FAIL lat_e4: got cnt %0d qv %b want 0/0", CNT, QV); end
  endtask

  task automatic test_stall_and_flush();
    logic [7:0] fill [4];
    fill = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_reset();
    EN = 1'b1; DV = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = fill[i];
      tick();
    end
    n_cmp++; if (Q !== 8'hA1 || CNT !== 3'd4) begin n_bad++; $display("FAIL stall_fill: got %h cnt %0d want a1/4", Q, CNT); end
    EN = 1'b0; D = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (Q !== 8'hA1 || QV !== 1'b1 || CNT !== 3'd4) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got %h/%b cnt %0d want a1/1/4", i, Q, QV, CNT);
      end
    end
    EN = 1'b1; D = 8'h00; DV = 1'b0;
    tick();
    n_cmp++; if (Q !== 8'hA2 || CNT !== 3'd3) begin n_bad++; $display("FAIL stall_resume: got %h cnt %0d want a2/3", Q, CNT); end
    // stages now (s0..s3): 00/0, A4/1, A3/1, A2/1
    FLUSH = 1'b1; EN = 1'b1; D = 8'h77; DV = 1'b1;
    tick();
    FLUSH = 1'b0;
    n_cmp++; if (QV !== 1'b0 || CNT !== 3'd0) begin n_bad++; $display("FAIL flush_tags: got qv %b cnt %0d want 0/0", QV, CNT); end
    n_cmp++; if (Q !== 8'hA2) begin n_bad++; $display("FAIL flush_data: got %h want a2", Q); end
    D = 8'h00; DV = 1'b0;
    tick();
    n_cmp++; if (Q !== 8'hA3 || QV !== 1'b0) begin n_bad++; $display("FAIL flush_shift1: got %h/%b want a3/0", Q, QV); end
    tick();
    n_cmp++; if (Q !== 8'hA4) begin n_bad++; $display("FAIL flush_shift2: got %h want a4", Q); end
    tick();
    n_cmp++; if (Q !== 8'h00 || CNT !== 3'd0) begin n_bad++; $display("FAIL flush_no_capture: got %h cnt %0d want 00/0", Q, CNT); end
  endtask

  task automatic test_async_reset();
    do_reset();
    EN = 1'b1;
    DV = 1'b1; D = 8'hB1; tick();
    D = 8'hB2; tick();
    DV = 1'b0; D = 8'h00; tick(); tick();
    n_cmp++; if (Q !== 8'hB1 || QV !== 1'b1 || CNT !== 3'd2) begin
      n_bad++; $display("FAIL arst_pre: got %h/%b cnt %0d want b1/1/2", Q, QV, CNT);
    end
    EN = 1'b0;
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (Q !== 8'h00 || QV !== 1'b0 || CNT !== 3'd0) begin
      n_bad++; $display("FAIL arst_now: got %h/%b cnt %0d want 00/0/0", Q, QV, CNT);
    end
    RST = 1'b0;
    EN = 1'b1;
    tick();
    n_cmp++; if (Q !== 8'h00 || QV !== 1'b0 || CNT !== 3'd0) begin
      n_bad++; $display("FAIL arst_flushed: got %h/%b cnt %0d want 00/0/0", Q, QV, CNT);
    end
  endtask

`ifdef DFFNQ_PIPE_BANK_SCAN_EN
  task automatic test_scan();
    logic [31:0] pat;
    pat = 32'hDEADBEEF;
    do_reset();
    EN = 1'b1; DV = 1'b1; D = 8'h11;
    tick(); tick();
    DV = 1'b0; tick(); tick();
    // tags s0..s3 = 0,0,1,1 -> QV=1, CNT=2
    SE = 1'b1; EN = 1'b1; FLUSH = 1'b1;
    for (int k = 0; k < 32; k++) begin
      SI = pat[31-k];
      tick();
    end
    n_cmp++; if (Q !== 8'hDE) begin n_bad++; $display("FAIL scan_load_q: got %h want de", Q); end
    SI = 1'b0;
    for (int j = 0; j < 32; j++) begin
      n_cmp++; if (SO !== pat[31-j]) begin n_bad++; $display("FAIL scan_so[%0d]: got %b want %b", j, SO, pat[31-j]); end
      tick();
    end
    n_cmp++; if (QV !== 1'b1 || CNT !== 3'd2) begin n_bad++; $display("FAIL scan_tags: got qv %b cnt %0d want 1/2", QV, CNT); end
    SE = 1'b0; FLUSH = 1'b0; EN = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_stall_and_flush();
    test_async_reset();
`ifdef DFFNQ_PIPE_BANK_SCAN_EN
    test_scan();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
